stereo_mixer: RTL and testbench
===============================

Name: stereo_mixer

Overview:
- Parametrised, clocked N-channel stereo mixer and panner; next generation of the three-voice combinational stereo conditioner.
- Sits between the per-voice tone generators and the I2S/PWM output stage; runs once per audio-rate sample strobe.
- Per channel: multi-level pan gain (not just on/off per side), channel enable mask, mono fallback.
- Accumulates channels serially, one channel per clock, then saturates and registers the output with a valid strobe.

Parameters:
- NUM_CH, 4, number of voice channels (>=1).
- SAMPLE_W, 16, signed sample width, in and out.
- PAN_W, 3, pan field width. PAN_MAX = 2^PAN_W-1.
- ACC_W, SAMPLE_W+PAN_W+$clog2(NUM_CH)+1, signed accumulator width (derived; do not override).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- sample_valid_in  input  1  one-cycle strobe: new sample set on note_data.
- note_data  input  NUM_CH*SAMPLE_W  signed samples, channel k at [k*SAMPLE_W +: SAMPLE_W].
- pan  input  NUM_CH*PAN_W  pan per channel, 0 = full left, PAN_MAX = full right.
- ch_enable  input  NUM_CH  1 = channel mixed, 0 = contributes zero.
- stereo_on  input  1  1 = panned stereo, 0 = mono (both sides identical).
- sample_l  output  SAMPLE_W  signed left output, registered.
- sample_r  output  SAMPLE_W  signed right output, registered.
- sample_valid_out  output  1  one-cycle strobe: new sample_l/sample_r.
- busy  output  1  mix in progress; new strobes are dropped.
- overrun  output  1  sticky: a strobe arrived while busy.
- clip_count  output  16  saturation event count (feature only; tied 0 otherwise).

Behaviour:
- Reset values: sample_l = 0, sample_r = 0, sample_valid_out = 0, busy = 0, overrun = 0, clip_count = 0. Reset also forces state to IDLE and clears both accumulators and the channel index.
- A reset mid-mix abandons the mix; no valid pulse follows.
- State machine:
  - IDLE: when sample_valid_in = 1, capture note_data, pan, ch_enable and stereo_on into shadow registers; clear acc_l and acc_r; set ch = 0; go to ACCUM.
  - ACCUM: add channel ch to acc_l and acc_r. If ch = NUM_CH-1, go to OUTPUT; else ch++.
  - OUTPUT: saturate, register sample_l and sample_r, pulse sample_valid_out, return to IDLE.
- Gains: stereo mode uses gl = PAN_MAX-pan[ch] and gr = pan[ch]. Mono mode uses gl = gr = PAN_MAX. Disabled channel: gl = gr = 0.
- Arithmetic:
  - Products are signed SAMPLE_W x unsigned (PAN_W+1), sign-extended to ACC_W.
  - Result = acc >>> PAN_W, arithmetic shift.
  - Saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Latency: strobe sampled at edge T; sample_valid_out is high in the cycle following edge T+NUM_CH+1, i.e. NUM_CH+2 cycles.
- busy is high from the cycle after acceptance through the OUTPUT cycle inclusive.
- Minimum strobe spacing is NUM_CH+2 cycles.
- A sample_valid_in during ACCUM or OUTPUT is ignored and sets overrun, which clears only on reset.
- A strobe in the same cycle that sample_valid_out is high (state IDLE) is accepted.
- Input changes after capture do not affect the mix in progress.
- sample_l and sample_r hold their value between valid pulses.

Optional Feature:
- Macro: STEREO_MIXER_CLIP_COUNT_EN.
- Defined: clip_count increments by 1 for each OUTPUT cycle in which either side saturated (both sides saturating counts 1). It saturates at 16'hFFFF and clears on reset.
- Undefined: no counter logic; clip_count is tied to 0.

Decomposition:
- Package mixer_pkg: state enum (IDLE, ACCUM, OUTPUT), the ACC_W derivation function, and the pan gain function (stereo_on, en, pan) -> (gl, gr).
- One sub-module, sample_saturate: parametrised ACC_W in, SAMPLE_W out. It performs the shift and clamp and outputs a clipped flag. Instantiate it twice, once for left and once for right.

Test Plan:
- Reset, then NUM_CH=4, all enabled, stereo_on=1, pan = {0,7,3,4}, samples = {800,800,800,800}, one strobe:
  - acc_l = 800*(7+0+4+3) = 11200, so sample_l = 1400.
  - acc_r = 800*(0+7+3+4) = 11200, so sample_r = 1400.
  - valid exactly 6 cycles after the strobe.
- stereo_on=0, samples = {1000,-200,0,0}, ch_enable = 4'b0011: both sides = (800*7)>>>3 = 700.
- All samples = 32767, stereo_on=0: both outputs 32767; with the feature, clip_count = 1. All samples = -32768: both outputs -32768.
- Second strobe 3 cycles after the first: exactly one valid pulse, overrun = 1. A strobe in the valid cycle is accepted and gives a second pulse 6 cycles later.
- rst_in asserted at cycle 2 of ACCUM: no valid pulse; all outputs return to reset values the next cycle. The next strobe mixes correctly.
- ch_enable = 0: outputs 0, valid still pulses.

Source files
------------

// File: rtl/mixer_pkg.sv
// mixer_pkg: shared FSM states, accumulator width derivation and pan gain law for stereo_mixer.
package mixer_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  typedef struct packed {
    logic [7:0] gl;
    logic [7:0] gr;
  } gain_t;
  function automatic int acc_width(input int sample_w, input int pan_w, input int num_ch);
    return sample_w + pan_w + $clog2(num_ch) + 1;
  endfunction
  function automatic gain_t pan_gain(input logic stereo, input logic en, input logic [7:0] pan,
                                     input logic [7:0] pan_max);
    gain_t g;
    g.gl = !en ? 8'd0 : stereo ? pan_max - pan : pan_max;
    g.gr = !en ? 8'd0 : stereo ? pan : pan_max;
    return g;
  endfunction
endpackage

// File: rtl/sample_saturate.sv
// sample_saturate: drops the pan gain scaling from an accumulator and clamps it to a signed sample.
module sample_saturate #(
  parameter int ACC_W = 22,
  parameter int SAMPLE_W = 16,
  parameter int SHIFT = 3
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       clipped
);
  logic signed [ACC_W-1:0] sh;
  always_comb begin
    sh = acc >>> SHIFT;
    // every bit above the sample's sign bit must match it, or the value is out of range
    clipped = sh[ACC_W-1:SAMPLE_W-1] != {(ACC_W-SAMPLE_W+1){sh[SAMPLE_W-1]}};
    sample = clipped ? {sh[ACC_W-1], {(SAMPLE_W-1){~sh[ACC_W-1]}}} : sh[SAMPLE_W-1:0];
  end
endmodule

// File: rtl/stereo_mixer.sv
// stereo_mixer: serial N-channel pan/mix with saturation; STEREO_MIXER_CLIP_COUNT_EN adds a clip event counter.
module stereo_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SAMPLE_W = 16,
  parameter int PAN_W = 3
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         sample_valid_in,
  input  logic [NUM_CH*SAMPLE_W-1:0]   note_data,
  input  logic [NUM_CH*PAN_W-1:0]      pan,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         stereo_on,
  output logic signed [SAMPLE_W-1:0]   sample_l,
  output logic signed [SAMPLE_W-1:0]   sample_r,
  output logic                         sample_valid_out,
  output logic                         busy,
  output logic                         overrun,
  output logic [15:0]                  clip_count
);
  localparam int ACC_W = acc_width(SAMPLE_W, PAN_W, NUM_CH);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [PAN_W-1:0] PAN_MAX = '1;
  state_t state, state_nx;
  logic [NUM_CH*SAMPLE_W-1:0] data_q;
  logic [NUM_CH*PAN_W-1:0] pan_q;
  logic [NUM_CH-1:0] en_q;
  logic stereo_q;
  logic [CH_W-1:0] ch;
  logic last;
  logic signed [ACC_W-1:0] acc_l, acc_r, smp, prod_l, prod_r;
  logic signed [SAMPLE_W-1:0] sat_l, sat_r;
  logic clip_l, clip_r;
  gain_t g;
  always_comb begin
    g = pan_gain(stereo_q, en_q[ch], 8'(pan_q[ch*PAN_W +: PAN_W]), 8'(PAN_MAX));
    smp = ACC_W'($signed(data_q[ch*SAMPLE_W +: SAMPLE_W]));
    prod_l = smp * $signed(ACC_W'(g.gl));
    prod_r = smp * $signed(ACC_W'(g.gr));
    last = ch == CH_W'(NUM_CH - 1);
    state_nx = state == IDLE  ? (sample_valid_in ? ACCUM : IDLE) :
               state == ACCUM ? (last ? OUTPUT : ACCUM) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      acc_l <= '0;
      acc_r <= '0;
      ch <= '0;
      sample_l <= '0;
      sample_r <= '0;
      sample_valid_out <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      sample_valid_out <= state == OUTPUT;
      if (sample_valid_in && busy) overrun <= 1'b1;
      if (state == IDLE && sample_valid_in) begin
        data_q <= note_data;
        pan_q <= pan;
        en_q <= ch_enable;
        stereo_q <= stereo_on;
        acc_l <= '0;
        acc_r <= '0;
        ch <= '0;
      end
      if (state == ACCUM) begin
        acc_l <= acc_l + prod_l;
        acc_r <= acc_r + prod_r;
        if (!last) ch <= ch + 1'b1;
      end
      if (state == OUTPUT) begin
        sample_l <= sat_l;
        sample_r <= sat_r;
      end
    end
  end
  sample_saturate #(.ACC_W(ACC_W), .SAMPLE_W(SAMPLE_W), .SHIFT(PAN_W)) u_sat_l (
    .acc(acc_l), .sample(sat_l), .clipped(clip_l));
  sample_saturate #(.ACC_W(ACC_W), .SAMPLE_W(SAMPLE_W), .SHIFT(PAN_W)) u_sat_r (
    .acc(acc_r), .sample(sat_r), .clipped(clip_r));
`ifdef STEREO_MIXER_CLIP_COUNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) clip_count <= '0;
    else if (state == OUTPUT && (clip_l || clip_r) && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
  end
`else
  logic unused_clip;
  assign unused_clip = clip_l | clip_r;
  assign clip_count = '0;
`endif
endmodule

// File: tb/tb_stereo_mixer.sv
// tb_stereo_mixer: directed vectors with a queue scoreboard checked by an independent output monitor.
module tb_stereo_mixer;
  logic clk_in = 1'b0;
  logic rst_in, sample_valid_in, stereo_on;
  logic [63:0] note_data;
  logic [11:0] pan;
  logic [3:0] ch_enable;
  logic signed [15:0] sample_l, sample_r;
  logic sample_valid_out, busy, overrun;
  logic [15:0] clip_count;
  typedef struct {int l; int r;} exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0, n_valid = 0, exp_clip = 0, lat, vb;

  stereo_mixer #(.NUM_CH(4), .SAMPLE_W(16), .PAN_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_valid_in(sample_valid_in), .note_data(note_data),
    .pan(pan), .ch_enable(ch_enable), .stereo_on(stereo_on), .sample_l(sample_l),
    .sample_r(sample_r), .sample_valid_out(sample_valid_out), .busy(busy), .overrun(overrun),
    .clip_count(clip_count));

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (sample_valid_out) begin
      n_valid++;
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("sample_l", sample_l, e.l);
        check("sample_r", sample_r, e.r);
      end
    end
  end

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [11:0] pp(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic drive(input logic [63:0] d, input logic [11:0] p, input logic [3:0] en, input logic st);
    note_data = d;
    pan = p;
    ch_enable = en;
    stereo_on = st;
    sample_valid_in = 1'b1;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_in);
      sample_valid_in = 1'b0;
      if (i == 1) check("busy_after_accept", busy, 1);
      if (sample_valid_out) begin
        l = i;
        break;
      end
    end
    if (l == 0) check("valid_timeout", 0, 1);
  endtask

  task automatic mix(input logic [63:0] d, input logic [11:0] p, input logic [3:0] en, input logic st,
                     input int el, input int er);
    int l;
    drive(d, p, en, st);
    sb.push_back('{el, er});
    wait_valid(l);
    check("latency", l, 6);
    @(negedge clk_in);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    sample_valid_in = 1'b0;
    note_data = '0;
    pan = '0;
    ch_enable = '0;
    stereo_on = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_sample_l", sample_l, 0);
    check("rst_sample_r", sample_r, 0);
    check("rst_valid", sample_valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_clip", clip_count, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    mix(pk(800, 800, 800, 800), pp(0, 7, 3, 4), 4'hF, 1'b1, 1400, 1400);
    mix(pk(1000, -200, 0, 0), pp(0, 0, 0, 0), 4'b0011, 1'b0, 700, 700);
    mix(pk(-1, 0, 0, 0), pp(0, 0, 0, 0), 4'b0001, 1'b0, -1, -1);
    mix(pk(100, -300, 2000, 0), pp(1, 2, 5, 7), 4'hF, 1'b1, 387, 1187);
    check("clip_none", clip_count, exp_clip);
    mix(pk(32767, 32767, 32767, 32767), pp(0, 0, 0, 0), 4'hF, 1'b0, 32767, 32767);
`ifdef STEREO_MIXER_CLIP_COUNT_EN
    exp_clip = 1;
`endif
    check("clip_pos", clip_count, exp_clip);
    mix(pk(-32768, -32768, -32768, -32768), pp(7, 0, 3, 4), 4'hF, 1'b0, -32768, -32768);
`ifdef STEREO_MIXER_CLIP_COUNT_EN
    exp_clip = 2;
`endif
    check("clip_neg", clip_count, exp_clip);
    check("overrun_clear", overrun, 0);
    mix(pk(5000, -5000, 1234, 77), pp(1, 2, 3, 4), 4'h0, 1'b1, 0, 0);
    // overrun: a second strobe mid-mix is dropped, a strobe in the valid cycle is taken
    vb = n_valid;
    drive(pk(800, 800, 800, 800), pp(0, 7, 3, 4), 4'hF, 1'b1);
    sb.push_back('{1400, 1400});
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    drive(pk(9000, 9000, 9000, 9000), pp(7, 7, 7, 7), 4'hF, 1'b1);
    wait_valid(lat);
    check("latency_overrun", lat, 3);
    check("overrun_set", overrun, 1);
    drive(pk(-1000, 0, 0, 0), pp(0, 0, 0, 0), 4'b0001, 1'b0);
    sb.push_back('{-875, -875});
    wait_valid(lat);
    check("latency_back_to_back", lat, 6);
    #1;
    check("pulse_count", n_valid - vb, 2);
    check("overrun_sticky", overrun, 1);
    @(negedge clk_in);
    // reset in the second ACCUM cycle abandons the mix
    drive(pk(800, 800, 800, 800), pp(0, 7, 3, 4), 4'hF, 1'b1);
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_sample_l", sample_l, 0);
    check("midrst_sample_r", sample_r, 0);
    check("midrst_valid", sample_valid_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_clip", clip_count, 0);
    exp_clip = 0;
    rst_in = 1'b0;
    vb = n_valid;
    repeat (10) @(negedge clk_in);
    #1;
    check("midrst_no_pulse", n_valid - vb, 0);
    mix(pk(800, 800, 800, 800), pp(0, 7, 3, 4), 4'hF, 1'b1, 1400, 1400);
    check("clip_after_rst", clip_count, exp_clip);
    repeat (2) @(negedge clk_in);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
